// File: rtl/a_16bits_rf_plus_alu_if.sv
// a_16bits_rf_plus_alu_if: control, data and result signals of the RF + ALU datapath slice
interface a_16bits_rf_plus_alu_if;
  logic        RF_Write_en;
  logic [2:0]  Rd_ddd_to_RF;
  logic [2:0]  Rm_mmm_to_RF;
  logic [2:0]  Rn_nnn_to_RF;
  logic        Mem_to_RF_Sel;
  logic [15:0] MemDataReg_to_RF;
  logic        RA_Data_CE;
  logic        RB_Data_CE;
  logic        ALU_A_Sel;
  logic [1:0]  ALU_B_Sel;
  logic [15:0] PC_to_ALU_A;
  logic [15:0] Instr;
  logic [1:0]  Imm_Sel;
  logic        ALU_Control;
  logic        ALUOut_CE;
  logic [15:0] ALU_S;
  logic [15:0] ALU_Out;
  logic [3:0]  NZVC;
  modport master (
    output RF_Write_en, Rd_ddd_to_RF, Rm_mmm_to_RF, Rn_nnn_to_RF, Mem_to_RF_Sel, MemDataReg_to_RF,
           RA_Data_CE, RB_Data_CE, ALU_A_Sel, ALU_B_Sel, PC_to_ALU_A, Instr, Imm_Sel, ALU_Control, ALUOut_CE,
    input  ALU_S, ALU_Out, NZVC
  );
  modport slave (
    input  RF_Write_en, Rd_ddd_to_RF, Rm_mmm_to_RF, Rn_nnn_to_RF, Mem_to_RF_Sel, MemDataReg_to_RF,
           RA_Data_CE, RB_Data_CE, ALU_A_Sel, ALU_B_Sel, PC_to_ALU_A, Instr, Imm_Sel, ALU_Control, ALUOut_CE,
    output ALU_S, ALU_Out, NZVC
  );
endinterface

// File: rtl/a_16bits_rf_plus_alu.sv
// a_16bits_rf_plus_alu: 8x16 register file, RA/RB operand registers, add/sub ALU with latched result and NZVC
module a_16bits_rf_plus_alu (
  input logic clk,
  input logic rst_n,
  a_16bits_rf_plus_alu_if.slave bus
);
  logic [15:0] rf [8];
  logic [15:0] ra, rb, imm, a, b, bx, s, wd, alu_out;
  logic [16:0] sum;
  logic [3:0] nzvc;
  logic v;
  // immediate generation, A/B source muxes, adder with carry/overflow and writeback select
  always_comb begin
    imm = bus.Imm_Sel == 2'b00 ? {{11{bus.Instr[4]}}, bus.Instr[4:0]} :
          bus.Imm_Sel == 2'b01 ? {{8{bus.Instr[7]}}, bus.Instr[7:0]} :
          bus.Imm_Sel == 2'b10 ? {8'h00, bus.Instr[7:0]} : 16'h0000;
    a = bus.ALU_A_Sel ? ra : bus.PC_to_ALU_A;
    b = bus.ALU_B_Sel == 2'b00 ? rb : bus.ALU_B_Sel == 2'b01 ? imm : bus.ALU_B_Sel == 2'b10 ? 16'h0001 : 16'h0000;
    bx = bus.ALU_Control ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {16'h0000, bus.ALU_Control};
    s = sum[15:0];
    v = (bus.ALU_Control ? a[15] != b[15] : a[15] == b[15]) && s[15] != a[15];
    wd = bus.Mem_to_RF_Sel ? bus.MemDataReg_to_RF : alu_out;
  end
  // register file write, operand capture (old value on same-edge write) and result/flag latch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      ra <= '0;
      rb <= '0;
      alu_out <= '0;
      nzvc <= '0;
    end else begin
      if (bus.RF_Write_en) rf[bus.Rd_ddd_to_RF] <= wd;
      if (bus.RA_Data_CE) ra <= rf[bus.Rm_mmm_to_RF];
      if (bus.RB_Data_CE) rb <= rf[bus.Rn_nnn_to_RF];
      if (bus.ALUOut_CE) begin
        alu_out <= s;
        nzvc <= {s[15], s == 16'h0000, v, sum[16]};
      end
    end
  assign bus.ALU_S = s;
  assign bus.ALU_Out = alu_out;
  assign bus.NZVC = nzvc;
endmodule

// File: tb/tb_a_16bits_rf_plus_alu.sv
// tb_a_16bits_rf_plus_alu: directed plus random checks of the RF + ALU slice against an integer reference model
module tb_a_16bits_rf_plus_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  a_16bits_rf_plus_alu_if bus ();
  a_16bits_rf_plus_alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [15:0] m_rf [8];
  logic [15:0] m_ra, m_rb, m_out;
  logic [3:0] m_nzvc;

  function automatic logic [15:0] ref_imm(input logic [15:0] ins, input logic [1:0] sel);
    int v;
    case (sel)
      2'd0: v = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
      2'd1: v = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
      2'd2: v = int'(ins[7:0]);
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic [15:0] s;
    logic n, z, v, c;
    ua = int'(a);
    ub = int'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    r = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    s = 16'(r);
    c = sub ? (ua >= ub) : (r > 65535);
    v = (sr > 32767) || (sr < -32768);
    n = s[15];
    z = (s == 16'h0000);
    return {n, z, v, c, s};
  endfunction

  function automatic logic [19:0] model_now();
    logic [15:0] a, b;
    a = bus.ALU_A_Sel ? m_ra : bus.PC_to_ALU_A;
    case (bus.ALU_B_Sel)
      2'd0: b = m_rb;
      2'd1: b = ref_imm(bus.Instr, bus.Imm_Sel);
      2'd2: b = 16'd1;
      default: b = 16'd0;
    endcase
    return ref_alu(a, b, bus.ALU_Control);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [19:0] r;
    logic [15:0] pa, pb, wd;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_ra = 0; m_rb = 0; m_out = 0; m_nzvc = 0;
    end else begin
      r = model_now();
      pa = m_rf[bus.Rm_mmm_to_RF];
      pb = m_rf[bus.Rn_nnn_to_RF];
      wd = bus.Mem_to_RF_Sel ? bus.MemDataReg_to_RF : m_out;
      if (bus.RF_Write_en) m_rf[bus.Rd_ddd_to_RF] = wd;
      if (bus.RA_Data_CE) m_ra = pa;
      if (bus.RB_Data_CE) m_rb = pb;
      if (bus.ALUOut_CE) begin
        m_out = r[15:0];
        m_nzvc = r[19:16];
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.RF_Write_en = 0; bus.Rd_ddd_to_RF = 0; bus.Rm_mmm_to_RF = 0; bus.Rn_nnn_to_RF = 0;
    bus.Mem_to_RF_Sel = 0; bus.MemDataReg_to_RF = 0; bus.RA_Data_CE = 0; bus.RB_Data_CE = 0;
    bus.ALU_A_Sel = 0; bus.ALU_B_Sel = 2'd3; bus.PC_to_ALU_A = 0; bus.Instr = 0; bus.Imm_Sel = 0;
    bus.ALU_Control = 0; bus.ALUOut_CE = 0;
  endtask

  task automatic load(input logic [2:0] rd, input logic [15:0] d);
    @(negedge clk);
    idle();
    bus.RF_Write_en = 1; bus.Rd_ddd_to_RF = rd; bus.Mem_to_RF_Sel = 1; bus.MemDataReg_to_RF = d;
  endtask

  task automatic op(input string tag, input logic [2:0] rm, input logic [2:0] rn, input logic asel,
                    input logic [1:0] bsel, input logic [15:0] ins, input logic [1:0] isel, input logic sub,
                    input logic [15:0] pc, input logic [15:0] exp_out, input logic [3:0] exp_f);
    @(negedge clk);
    idle();
    bus.Rm_mmm_to_RF = rm; bus.Rn_nnn_to_RF = rn; bus.RA_Data_CE = 1; bus.RB_Data_CE = 1;
    @(negedge clk);
    idle();
    bus.ALU_A_Sel = asel; bus.ALU_B_Sel = bsel; bus.Instr = ins; bus.Imm_Sel = isel;
    bus.ALU_Control = sub; bus.PC_to_ALU_A = pc; bus.ALUOut_CE = 1;
    @(negedge clk);
    idle();
    chk({tag, ".out"}, bus.ALU_Out, exp_out);
    chk({tag, ".nzvc"}, {12'h0, bus.NZVC}, {12'h0, exp_f});
    chk({tag, ".model"}, bus.ALU_Out, m_out);
  endtask

  initial begin
    logic [15:0] held;
    logic [19:0] r;
    idle();
    #1;
    chk("reset.out", bus.ALU_Out, 16'h0);
    chk("reset.nzvc", {12'h0, bus.NZVC}, 16'h0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) load(3'(i), 16'(i));
    op("add_r3_r5", 3, 5, 1, 2'd0, 0, 0, 0, 0, 16'h0008, 4'b0000);
    op("add_r2_r7", 2, 7, 1, 2'd0, 0, 0, 0, 0, 16'h0009, 4'b0000);
    op("add_r0_r5", 0, 5, 1, 2'd0, 0, 0, 0, 0, 16'h0005, 4'b0000);
    op("sub_r5_r3", 5, 3, 1, 2'd0, 0, 0, 1, 0, 16'h0002, 4'b0001);
    op("sub_r3_r5", 3, 5, 1, 2'd0, 0, 0, 1, 0, 16'hFFFE, 4'b1000);
    op("imm5_pos", 4, 0, 1, 2'd1, 16'h0003, 2'd0, 0, 0, 16'h0007, 4'b0000);
    op("imm5_neg", 5, 0, 1, 2'd1, 16'h0018, 2'd0, 0, 0, 16'hFFFD, 4'b1000);
    op("imm8_pos", 4, 0, 1, 2'd1, 16'h007F, 2'd1, 0, 0, 16'h0083, 4'b0000);
    op("imm8_neg", 3, 0, 1, 2'd1, 16'h0080, 2'd1, 0, 0, 16'hFF83, 4'b1000);
    op("imm8_zext", 2, 0, 1, 2'd1, 16'h00FF, 2'd2, 0, 0, 16'h0101, 4'b0000);
    op("imm_zero", 1, 0, 1, 2'd1, 16'hFFFF, 2'd3, 0, 0, 16'h0001, 4'b0000);
    op("pc_plus1", 0, 0, 0, 2'd2, 0, 0, 0, 16'h1000, 16'h1001, 4'b0000);
    op("pc_plus0", 0, 0, 0, 2'd3, 0, 0, 0, 16'h1000, 16'h1000, 4'b0000);
    @(negedge clk);
    idle();
    bus.PC_to_ALU_A = 16'h2222; bus.ALU_B_Sel = 2'd2;
    #1;
    chk("hold.alu_s", bus.ALU_S, 16'h2223);
    @(negedge clk);
    chk("hold.out", bus.ALU_Out, 16'h1000);
    chk("hold.nzvc", {12'h0, bus.NZVC}, 16'h0);
    load(1, 16'h7FFF);
    op("ovf_pos", 1, 0, 1, 2'd2, 0, 0, 0, 0, 16'h8000, 4'b1010);
    load(1, 16'hFFFF);
    op("wrap_zero", 1, 0, 1, 2'd2, 0, 0, 0, 0, 16'h0000, 4'b0101);
    op("pre_wb", 0, 0, 0, 2'd2, 0, 0, 0, 16'h4321, 16'h4322, 4'b0000);
    @(negedge clk);
    idle();
    bus.RF_Write_en = 1; bus.Rd_ddd_to_RF = 6; bus.Mem_to_RF_Sel = 0;
    bus.ALUOut_CE = 1; bus.PC_to_ALU_A = 16'h0AAA; bus.ALU_B_Sel = 2'd3;
    @(negedge clk);
    idle();
    chk("same_edge.out", bus.ALU_Out, 16'h0AAA);
    bus.Rm_mmm_to_RF = 6; bus.RA_Data_CE = 1;
    @(negedge clk);
    idle();
    bus.ALU_A_Sel = 1;
    #1;
    chk("same_edge.r6", bus.ALU_S, 16'h4322);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      chk("rand.out", bus.ALU_Out, m_out);
      chk("rand.nzvc", {12'h0, bus.NZVC}, {12'h0, m_nzvc});
      if (k == 150) begin
        idle();
        #2;
        rst_n = 0;
        #1;
        chk("midreset.out", bus.ALU_Out, 16'h0);
        chk("midreset.nzvc", {12'h0, bus.NZVC}, 16'h0);
        bus.ALU_A_Sel = 1; bus.ALU_B_Sel = 2'd3;
        #1;
        chk("midreset.ra", bus.ALU_S, 16'h0);
        bus.ALU_A_Sel = 0; bus.ALU_B_Sel = 2'd0; bus.PC_to_ALU_A = 16'h1234;
        #1;
        chk("midreset.rb", bus.ALU_S, 16'h1234);
        @(negedge clk);
        rst_n = 1;
        bus.Rm_mmm_to_RF = 7; bus.RA_Data_CE = 1;
        @(negedge clk);
        idle();
        bus.ALU_A_Sel = 1;
        #1;
        chk("midreset.rf", bus.ALU_S, 16'h0);
      end
      bus.RF_Write_en = 1'($urandom); bus.Rd_ddd_to_RF = 3'($urandom); bus.Rm_mmm_to_RF = 3'($urandom);
      bus.Rn_nnn_to_RF = 3'($urandom); bus.Mem_to_RF_Sel = 1'($urandom); bus.MemDataReg_to_RF = 16'($urandom);
      bus.RA_Data_CE = 1'($urandom); bus.RB_Data_CE = 1'($urandom); bus.ALU_A_Sel = 1'($urandom);
      bus.ALU_B_Sel = 2'($urandom); bus.PC_to_ALU_A = 16'($urandom); bus.Instr = 16'($urandom);
      bus.Imm_Sel = 2'($urandom); bus.ALU_Control = 1'($urandom); bus.ALUOut_CE = 1'($urandom);
      #1;
      r = model_now();
      chk("rand.alu_s", bus.ALU_S, r[15:0]);
    end
    @(negedge clk);
    chk("final.out", bus.ALU_Out, m_out);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
